regfile_mp_sb: RTL and testbench

- Parametrised successor to the core's single-write register file, sitting in the ID/WB stage.
- Provides three combinational read ports and two prioritised write ports (WB0, WB1).
- Adds optional write-to-read bypass, a hard-wired zero register, and a per-register pending (scoreboard) bit.
- Decode uses the pending bits to stall on unresolved producers.

---
 rtl/regfile_mp_sb.sv | 195 +++++++++++++++++++
 tb/tb_regfile_mp_sb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
//
// ID/WB register file with three combinational read ports, two prioritised
// write ports and a per-register pending (scoreboard) bit used by decode to
// stall on unresolved producers.
//
// Parameters
//   DATA_W   : register width
//   ADDR_W   : address width, depth = 2**ADDR_W
//   ZERO_REG : 1 -> register 0 reads 0, ignores writes and issues
//   BYPASS   : 1 -> an enabled same-cycle write is forwarded to read data/ready
//
// Ports
//   CLK, RESET                  : clock, asynchronous active-low reset
//   RegA1/RegB1/RegC1           : read addresses
//   DataA1/DataB1/DataC1        : read data (combinational)
//   ReadyA1/ReadyB1/ReadyC1     : addressed register has no pending producer
//   WriteReg1/WriteData1/Write1 : write port 1
//   WriteReg2/WriteData2/Write2 : write port 2 (wins on a same-address clash)
//   IssueReg/Issue              : mark IssueReg pending
//   PendingCount                : registered population count of pending bits
// -----------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,

  input  logic [ADDR_W-1:0] RegA1,
  input  logic [ADDR_W-1:0] RegB1,
  input  logic [ADDR_W-1:0] RegC1,
  output logic [DATA_W-1:0] DataA1,
  output logic [DATA_W-1:0] DataB1,
  output logic [DATA_W-1:0] DataC1,
  output logic              ReadyA1,
  output logic              ReadyB1,
  output logic              ReadyC1,

  input  logic [ADDR_W-1:0] WriteReg1,
  input  logic [DATA_W-1:0] WriteData1,
  input  logic              Write1,

  input  logic [ADDR_W-1:0] WriteReg2,
  input  logic [DATA_W-1:0] WriteData2,
  input  logic              Write2,

  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              Issue,

  output logic [ADDR_W:0]   PendingCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned N_RD  = 3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic [ADDR_W:0]   pend_cnt;
  logic [ADDR_W:0]   pend_cnt_nxt;

  // True when the address is the hard-wired zero register.
  function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // ---------------------------------------------------------------------------
  // Qualified enables. Gating with RESET keeps in-flight writes from being
  // forwarded while reset is held, so outputs sit at their reset values.
  // ---------------------------------------------------------------------------
  logic wr1_en;
  logic wr2_en;
  logic iss_en;

  assign wr1_en = RESET && Write1 && !is_zero(WriteReg1);
  assign wr2_en = RESET && Write2 && !is_zero(WriteReg2);
  assign iss_en = RESET && Issue  && !is_zero(IssueReg);

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr  [N_RD];
  logic [DATA_W-1:0] rd_data  [N_RD];
  logic              rd_ready [N_RD];

  assign rd_addr[0] = RegA1;
  assign rd_addr[1] = RegB1;
  assign rd_addr[2] = RegC1;

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    logic hit1;
    logic hit2;

    assign hit1 = BYPASS && wr1_en && (WriteReg1 == rd_addr[p]);
    assign hit2 = BYPASS && wr2_en && (WriteReg2 == rd_addr[p]);

    // NOTE: every output gets a value before any branch so no latch is inferred.
    always_comb begin
      rd_data[p]  = regs[rd_addr[p]];
      rd_ready[p] = !pending[rd_addr[p]];
      if (is_zero(rd_addr[p])) begin
        rd_data[p]  = '0;
        rd_ready[p] = 1'b1;
      end else begin
        // Port 2 has priority, matching what the register holds after the edge.
        if (hit2) begin
          rd_data[p] = WriteData2;
        end else if (hit1) begin
          rd_data[p] = WriteData1;
        end
        // A retiring producer makes the value available now; a same-cycle
        // issue only takes effect on the pending bit after the edge.
        if (hit1 || hit2) begin
          rd_ready[p] = 1'b1;
        end
      end
    end
  end

  assign DataA1  = rd_data[0];
  assign DataB1  = rd_data[1];
  assign DataC1  = rd_data[2];
  assign ReadyA1 = rd_ready[0];
  assign ReadyB1 = rd_ready[1];
  assign ReadyC1 = rd_ready[2];

  // ---------------------------------------------------------------------------
  // Register array
  // ---------------------------------------------------------------------------
  // Port 1 is suppressed on an address clash so port 2 wins without relying on
  // statement order.
  logic wr1_take;
  assign wr1_take = wr1_en && !(wr2_en && (WriteReg1 == WriteReg2));

  // NOTE: the array is reset explicitly because every address must read 0 out
  // of reset; this forces flops rather than a RAM macro, which is acceptable
  // at this depth.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr1_take) begin
        regs[WriteReg1] <= WriteData1;
      end
      if (wr2_en) begin
        regs[WriteReg2] <= WriteData2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard: set beats clear, because the issuing instruction is a newer
  // producer than the one retiring in the same cycle.
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] one_hot;

  assign one_hot = {{(DEPTH-1){1'b0}}, 1'b1};
  assign set_vec = iss_en ? (one_hot << IssueReg) : '0;
  assign clr_vec = (wr1_en ? (one_hot << WriteReg1) : '0)
                 | (wr2_en ? (one_hot << WriteReg2) : '0);

  always_comb begin
    pending_nxt  = set_vec | (pending & ~clr_vec);
    pend_cnt_nxt = '0;
    for (int r = 0; r < DEPTH; r++) begin
      pend_cnt_nxt = pend_cnt_nxt + (ADDR_W+1)'(pending_nxt[r]);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

  assign PendingCount = pend_cnt;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
//
// Drives two instances of regfile_mp_sb from the same inputs:
//   cfg 0 : ZERO_REG=1, BYPASS=1
//   cfg 1 : ZERO_REG=0, BYPASS=0
// and compares both against an array-based reference model of the register
// file contents, pending set and pending count.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra, rb, rc;
  logic [4:0]  w1_reg, w2_reg, iss_reg;
  logic [31:0] w1_data, w2_data;
  logic        w1, w2, iss;

  logic [31:0] da0, db0, dc0, da1, db1, dc1;
  logic        ya0, yb0, yc0, ya1, yb1, yc1;
  logic [5:0]  pc0, pc1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state, indexed by configuration.
  logic [31:0] m_reg  [2][32];
  bit          m_pend [2][32];
  int          m_cnt  [2];
  bit          cfg_zero [2] = '{1'b1, 1'b0};
  bit          cfg_byp  [2] = '{1'b1, 1'b0};

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .CLK(clk), .RESET(rst_n),
    .RegA1(ra), .RegB1(rb), .RegC1(rc),
    .DataA1(da0), .DataB1(db0), .DataC1(dc0),
    .ReadyA1(ya0), .ReadyB1(yb0), .ReadyC1(yc0),
    .WriteReg1(w1_reg), .WriteData1(w1_data), .Write1(w1),
    .WriteReg2(w2_reg), .WriteData2(w2_data), .Write2(w2),
    .IssueReg(iss_reg), .Issue(iss),
    .PendingCount(pc0)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .CLK(clk), .RESET(rst_n),
    .RegA1(ra), .RegB1(rb), .RegC1(rc),
    .DataA1(da1), .DataB1(db1), .DataC1(dc1),
    .ReadyA1(ya1), .ReadyB1(yb1), .ReadyC1(yc1),
    .WriteReg1(w1_reg), .WriteData1(w1_data), .Write1(w1),
    .WriteReg2(w2_reg), .WriteData2(w2_data), .Write2(w2),
    .IssueReg(iss_reg), .Issue(iss),
    .PendingCount(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit write_hits(int c, logic [4:0] a);
    if (cfg_zero[c] && a == 5'd0) return 1'b0;
    return (w1 && w1_reg == a) || (w2 && w2_reg == a);
  endfunction

  function automatic logic [31:0] exp_data(int c, logic [4:0] a);
    if (!rst_n) return 32'h0;
    if (cfg_zero[c] && a == 5'd0) return 32'h0;
    if (cfg_byp[c]) begin
      if (w2 && w2_reg == a) return w2_data;
      if (w1 && w1_reg == a) return w1_data;
    end
    return m_reg[c][a];
  endfunction

  function automatic logic exp_ready(int c, logic [4:0] a);
    if (!rst_n) return 1'b1;
    if (cfg_zero[c] && a == 5'd0) return 1'b1;
    if (cfg_byp[c] && write_hits(c, a)) return 1'b1;
    return !m_pend[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[c][r]  = 32'h0;
        m_pend[c][r] = 1'b0;
      end
      m_cnt[c] = 0;
    end
  endtask

  task automatic model_edge();
    bit set, clr;
    for (int c = 0; c < 2; c++) begin
      // Port 1 first, port 2 second: port 2 wins on the same register.
      if (w1 && !(cfg_zero[c] && w1_reg == 5'd0)) m_reg[c][w1_reg] = w1_data;
      if (w2 && !(cfg_zero[c] && w2_reg == 5'd0)) m_reg[c][w2_reg] = w2_data;
      m_cnt[c] = 0;
      for (int r = 0; r < 32; r++) begin
        set = iss && iss_reg == 5'(r) && !(cfg_zero[c] && r == 0);
        clr = write_hits(c, 5'(r));
        if (set)      m_pend[c][r] = 1'b1;
        else if (clr) m_pend[c][r] = 1'b0;
        m_cnt[c] += int'(m_pend[c][r]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reads();
    chk("c0_data_a", da0, exp_data(0, ra));
    chk("c0_data_b", db0, exp_data(0, rb));
    chk("c0_data_c", dc0, exp_data(0, rc));
    chk("c0_rdy_a", 32'(ya0), 32'(exp_ready(0, ra)));
    chk("c0_rdy_b", 32'(yb0), 32'(exp_ready(0, rb)));
    chk("c0_rdy_c", 32'(yc0), 32'(exp_ready(0, rc)));
    chk("c1_data_a", da1, exp_data(1, ra));
    chk("c1_data_b", db1, exp_data(1, rb));
    chk("c1_data_c", dc1, exp_data(1, rc));
    chk("c1_rdy_a", 32'(ya1), 32'(exp_ready(1, ra)));
    chk("c1_rdy_b", 32'(yb1), 32'(exp_ready(1, rb)));
    chk("c1_rdy_c", 32'(yc1), 32'(exp_ready(1, rc)));
  endtask

  task automatic check_counts();
    chk("c0_pcount", 32'(pc0), 32'(m_cnt[0]));
    chk("c1_pcount", 32'(pc1), 32'(m_cnt[1]));
  endtask

  // Inputs are already applied; check reads, take the edge, check the count.
  task automatic step();
    #1;
    check_reads();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_counts();
  endtask

  task automatic idle();
    w1 = 1'b0; w2 = 1'b0; iss = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    ra = '0; rb = '0; rc = '0;
    w1_reg = '0; w2_reg = '0; iss_reg = '0;
    w1_data = '0; w2_data = '0;
    idle();
    model_reset();

    // Reset values while reset is held.
    #2;
    check_reads();
    check_counts();
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset state reads.
    ra = 5'd0; rb = 5'd5; rc = 5'd31;
    step();

    // Single write with same-cycle read, then the following cycle.
    w1 = 1'b1; w1_reg = 5'd7; w1_data = 32'hDEADBEEF; ra = 5'd7;
    step();
    idle();
    step();

    // Same-address clash, then two different addresses in one edge.
    w1 = 1'b1; w1_reg = 5'd9; w1_data = 32'h11;
    w2 = 1'b1; w2_reg = 5'd9; w2_data = 32'h22; ra = 5'd9;
    step();
    w1_reg = 5'd3; w1_data = 32'h33;
    w2_reg = 5'd4; w2_data = 32'h44; rb = 5'd3; rc = 5'd4;
    step();
    idle();
    step();
    chk("r9_port2_wins", da0, 32'h22);

    // Issue, retire through port 2, then re-issue with a same-cycle write.
    iss = 1'b1; iss_reg = 5'd12; ra = 5'd12;
    step();
    chk("pcount_after_issue", 32'(pc0), 32'd1);
    idle();
    step();
    w2 = 1'b1; w2_reg = 5'd12; w2_data = 32'h5;
    step();
    chk("pcount_after_retire", 32'(pc0), 32'd0);
    idle();
    iss = 1'b1;
    step();
    iss = 1'b1; w1 = 1'b1; w1_reg = 5'd12; w1_data = 32'h77;
    step();
    chk("pcount_issue_beats_write", 32'(pc0), 32'd1);
    idle();
    step();

    // Zero register: write and issue to address 0.
    w1 = 1'b1; w1_reg = 5'd0; w1_data = 32'hFFFFFFFF;
    iss = 1'b1; iss_reg = 5'd0; ra = 5'd0;
    step();
    idle();
    step();
    chk("zero_reg_data", da0, 32'h0);

    // Randomised traffic, biased to a few registers so clashes happen often.
    for (int i = 0; i < 400; i++) begin
      w1      = 1'($urandom_range(0, 1));
      w2      = 1'($urandom_range(0, 1));
      iss     = 1'($urandom_range(0, 1));
      w1_reg  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w2_reg  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      iss_reg = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      w1_data = $urandom;
      w2_data = $urandom;
      ra      = 5'($urandom_range(0, 7));
      rb      = 5'($urandom);
      rc      = 5'($urandom_range(0, 7));
      step();
    end

    // Clear the scoreboard, then make exactly three registers pending.
    idle();
    for (int r = 0; r < 32; r++) begin
      w1 = 1'b1; w1_reg = 5'(r); w1_data = 32'(r) * 32'h0101;
      step();
    end
    idle();
    for (int r = 1; r <= 3; r++) begin
      iss = 1'b1; iss_reg = 5'(r);
      step();
    end
    idle();
    chk("three_pending", 32'(pc0), 32'd3);

    // Mid-cycle reset with a write and an issue in flight.
    w1 = 1'b1; w1_reg = 5'd5; w1_data = 32'hAAAA5555;
    iss = 1'b1; iss_reg = 5'd6;
    ra = 5'd1; rb = 5'd2; rc = 5'd5;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_reads();
    check_counts();
    @(posedge clk);
    #1;
    check_reads();
    check_counts();
    #2 rst_n = 1'b1;
    idle();
    ra = 5'd5; rb = 5'd6; rc = 5'd3;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
